matrix_row_sequencer: RTL

Controller that runs an element-wise (Hadamard) product of two 4×4 signed 32-bit matrices through the shared scalar multiplicator datapath, one row at a time. It fetches row pairs from the A/B matrix buffers, issues each pair to the multiplicator with the multiply op-code, waits for its Done, and writes the result row into the result buffer. It sits between ALU control (Start/Operation/Done/Error) and the multiplicator plus matrix buffers.

---
 rtl/matrix_row_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/matrix_row_sequencer.sv
// ---------------------------------------------------------------------------
// matrix_row_sequencer
//
// Runs an element-wise (Hadamard) product of two ROWS x ROWS signed matrices
// through the shared scalar multiplicator, one row at a time. Each row pair is
// fetched from the A/B buffers, issued to the multiplicator with the multiply
// op-code, and the returned product row is written to the result buffer.
//
// Optional feature macro: ROW_TIMEOUT_EN
//   When defined, a per-row WAIT-cycle counter aborts the job if the
//   multiplicator stays silent for TIMEOUT_CYC consecutive WAIT cycles.
//
// Ports:
//   Clock, ClearAll_n        system clock (rising edge), async active-low reset
//   Start, Operation         job request from ALU control (only 3'b100 legal)
//   Busy, Done, Error        job status (Done is a pulse, Error is sticky)
//   RowAddr, RowA, RowB      row fetch from the combinational-read A/B buffers
//   MulOperation, MulEnable  op-code and issue strobe to the multiplicator
//   MulClearAll              multiplicator clear pulse, only on an abort
//   MulColumnA, MulColumnB   registered operand rows to the multiplicator
//   MulDone, MulError        multiplicator status
//   MulResult                product row from the multiplicator
//   WrEn, WrAddr, WrData     result-buffer write port
// ---------------------------------------------------------------------------
module matrix_row_sequencer #(
  parameter int DATA_W      = 32,
  parameter int ROWS        = 4,
  parameter int TIMEOUT_CYC = 8,
  localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   Clock,
  input  logic                   ClearAll_n,
  input  logic                   Start,
  input  logic [2:0]             Operation,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error,
  output logic [ROW_W-1:0]       RowAddr,
  input  logic [ROWS*DATA_W-1:0] RowA,
  input  logic [ROWS*DATA_W-1:0] RowB,
  output logic [2:0]             MulOperation,
  output logic                   MulEnable,
  output logic                   MulClearAll,
  output logic [ROWS*DATA_W-1:0] MulColumnA,
  output logic [ROWS*DATA_W-1:0] MulColumnB,
  input  logic                   MulDone,
  input  logic                   MulError,
  input  logic [ROWS*DATA_W-1:0] MulResult,
  output logic                   WrEn,
  output logic [ROW_W-1:0]       WrAddr,
  output logic [ROWS*DATA_W-1:0] WrData
);

  localparam logic [2:0]       OP_MUL   = 3'b100;
  localparam logic [2:0]       OP_NONE  = 3'b000;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    WRITE,
    FINISH
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [ROW_W-1:0] rowIdx;
  logic             abortedJob;
  logic             timeoutHit;
  logic             startLegal;

  assign startLegal = (Operation == OP_MUL);

`ifdef ROW_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] waitCnt;

  // The counter holds the number of silent WAIT cycles already completed, so
  // the abort fires at the end of the TIMEOUT_CYC-th silent cycle.
  always_comb begin
    timeoutHit = (waitCnt == CNT_W'(TIMEOUT_CYC - 1));
  end

  // Silent-cycle counter, restarted every time a row is issued.
  always_ff @(posedge Clock or negedge ClearAll_n) begin
    if (!ClearAll_n) begin
      waitCnt <= '0;
    end else if (state == ISSUE) begin
      waitCnt <= '0;
    end else if (state == WAIT && !MulError && !MulDone && !timeoutHit) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end
`else
  // Without the timeout feature WAIT holds until the multiplicator answers.
  always_comb begin
    timeoutHit = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge Clock or negedge ClearAll_n) begin
    if (!ClearAll_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic. MulError outranks MulDone, and a timeout only counts
  // when the multiplicator has said nothing at all in this cycle.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (Start) begin
          stateNext = startLegal ? FETCH : FINISH;
        end
      end
      FETCH:  stateNext = ISSUE;
      ISSUE:  stateNext = WAIT;
      WAIT: begin
        if (MulError) begin
          stateNext = FINISH;
        end else if (MulDone) begin
          stateNext = WRITE;
        end else if (timeoutHit) begin
          stateNext = FINISH;
        end
      end
      WRITE:  stateNext = (rowIdx == LAST_ROW) ? FINISH : FETCH;
      FINISH: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Job bookkeeping and datapath registers: row index, sticky error, abort
  // flag (drives the multiplicator clear in FINISH), operand and result rows.
  // An illegal op-code raises Error but is not an abort, since nothing was
  // ever issued to the multiplicator.
  always_ff @(posedge Clock or negedge ClearAll_n) begin
    if (!ClearAll_n) begin
      rowIdx     <= '0;
      Error      <= 1'b0;
      abortedJob <= 1'b0;
      MulColumnA <= '0;
      MulColumnB <= '0;
      WrData     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            rowIdx     <= '0;
            abortedJob <= 1'b0;
            Error      <= !startLegal;
          end
        end
        FETCH: begin
          MulColumnA <= RowA;
          MulColumnB <= RowB;
        end
        WAIT: begin
          if (MulError || (!MulDone && timeoutHit)) begin
            Error      <= 1'b1;
            abortedJob <= 1'b1;
          end else if (MulDone) begin
            WrData <= MulResult;
          end
        end
        WRITE: begin
          if (rowIdx != LAST_ROW) begin
            rowIdx <= rowIdx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode. Everything is a function of the state and the registered
  // row index, so reset forces all strobes low immediately.
  always_comb begin
    Busy         = (state != IDLE);
    Done         = (state == FINISH);
    MulClearAll  = (state == FINISH) && abortedJob;
    MulEnable    = (state == ISSUE);
    MulOperation = (state == ISSUE) ? OP_MUL : OP_NONE;
    WrEn         = (state == WRITE);
    WrAddr       = rowIdx;
    RowAddr      = rowIdx;
  end

endmodule
